pipe_run_ctl: RTL

- Run controller for the 5-stage 16-bit pipeline; decides each cycle whether the pipeline advances.
- Replaces the raw PAUSE gating with a sequenced controller supporting four modes:
  - free run (switch-controlled);
  - single step (debounced STEP button pulse);
  - run-N-cycles;
  - PC breakpoint.
- Also drains the pipeline cleanly on a HALT opcode.
- Drives fetch_en (PC and IF/ID), pipe_en (ID/EX, EX/MEM, MEM/WB) and id_bubble (ID/EX loads zeroed controls).

---
 rtl/pipe_run_ctl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/pipe_run_ctl.sv
// Run controller for the 5-stage pipeline: free run, single step, run-N,
// PC breakpoint and HALT drain, producing the per-stage load enables.
module pipe_run_ctl #(
  parameter int unsigned PC_W         = 8,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned CYC_W        = 32,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             pause_sw,
  input  logic             step_pulse,
  input  logic             run_n_start,
  input  logic [CNT_W-1:0] run_n_count,
  input  logic             bp_en,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic [PC_W-1:0]  pc,
  input  logic             halt_decoded,
  output logic             fetch_en,
  output logic             pipe_en,
  output logic             id_bubble,
  output logic [2:0]       state,
  output logic [2:0]       stop_reason,
  output logic [CYC_W-1:0] cycle_count
);

  localparam int unsigned DRN_W = $clog2(DRAIN_CYCLES + 1);

  localparam logic [2:0] S_STOPPED = 3'd0;
  localparam logic [2:0] S_RUN     = 3'd1;
  localparam logic [2:0] S_STEP    = 3'd2;
  localparam logic [2:0] S_RUNN    = 3'd3;
  localparam logic [2:0] S_DRAIN   = 3'd4;
  localparam logic [2:0] S_HALTED  = 3'd5;

  localparam logic [2:0] R_NONE  = 3'd0;
  localparam logic [2:0] R_PAUSE = 3'd1;
  localparam logic [2:0] R_BP    = 3'd2;
  localparam logic [2:0] R_COUNT = 3'd3;
  localparam logic [2:0] R_HALT  = 3'd4;
  localparam logic [2:0] R_STEP  = 3'd5;

  logic [CNT_W-1:0] runn_cnt, runn_d;
  logic [DRN_W-1:0] drain_cnt, drain_d;
  logic             bp_armed, armed_d;
  logic [2:0]       state_d, reason_d;
  logic [CYC_W-1:0] cyc_d;
  logic             bp_hit;

  // State and bookkeeping registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= S_STOPPED;
      stop_reason <= R_NONE;
      cycle_count <= '0;
      runn_cnt    <= '0;
      drain_cnt   <= '0;
      bp_armed    <= 1'b1;
    end else begin
      state       <= state_d;
      stop_reason <= reason_d;
      cycle_count <= cyc_d;
      runn_cnt    <= runn_d;
      drain_cnt   <= drain_d;
      bp_armed    <= armed_d;
    end
  end

  // Next-state and enable decode; the enables must react to bp_hit in the same cycle
  always_comb begin
    state_d   = state;
    reason_d  = stop_reason;
    runn_d    = runn_cnt;
    drain_d   = drain_cnt;
    armed_d   = bp_armed;
    cyc_d     = cycle_count;
    fetch_en  = 1'b0;
    pipe_en   = 1'b0;
    id_bubble = 1'b0;
    bp_hit    = bp_en & bp_armed & (pc == bp_addr);

    case (state)
      S_STOPPED: begin
        if (step_pulse) begin
          state_d = S_STEP;
        end else if (run_n_start && (run_n_count != '0)) begin
          state_d = S_RUNN;
          runn_d  = run_n_count;
        end else if (!pause_sw) begin
          state_d = S_RUN;
        end
      end
      S_RUN, S_STEP, S_RUNN: begin
        fetch_en = ~bp_hit;
        pipe_en  = ~bp_hit;
        if (state == S_RUNN && !bp_hit) runn_d = runn_cnt - CNT_W'(1);
        if (bp_hit) begin
          state_d  = S_STOPPED;
          reason_d = R_BP;
          armed_d  = 1'b0;
        end else if (halt_decoded) begin
          state_d  = S_DRAIN;
          reason_d = R_HALT;
          drain_d  = DRN_W'(DRAIN_CYCLES);
        end else if (state == S_RUN) begin
          if (pause_sw) begin
            state_d  = S_STOPPED;
            reason_d = R_PAUSE;
          end
        end else if (state == S_STEP) begin
          state_d  = S_STOPPED;
          reason_d = R_STEP;
        end else if (runn_cnt == CNT_W'(1)) begin
          state_d  = S_STOPPED;
          reason_d = R_COUNT;
        end
      end
      S_DRAIN: begin
        pipe_en   = 1'b1;
        id_bubble = 1'b1;
        drain_d   = drain_cnt - DRN_W'(1);
        if (drain_cnt == DRN_W'(1)) state_d = S_HALTED;
      end
      S_HALTED: begin
      end
      default: state_d = S_STOPPED;
    endcase

    // Any advance re-arms the breakpoint so a resume steps past it
    if (pipe_en) begin
      armed_d = 1'b1;
      if (cycle_count != '1) cyc_d = cycle_count + CYC_W'(1);
    end
  end

endmodule
